// File: rtl/write_back_unit_if.sv
// Write-back buffer handshake plus register-file write port of the write-back unit.
// master = upstream buffer / observer side, slave = write_back_unit.
interface write_back_unit_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
);
    logic              inValid;
    logic              inReady;
    logic              inWriteEnable1;
    logic [ADDR_W-1:0] inAddress1;
    logic [DATA_W-1:0] inData1;
    logic              inWriteEnable2;
    logic [ADDR_W-1:0] inAddress2;
    logic [DATA_W-1:0] inData2;
    logic              writeEnable;
    logic [ADDR_W-1:0] writeAddress;
    logic [DATA_W-1:0] writeData;
    logic [CNT_W-1:0]  retireCount;

    modport master (
        output inValid, inWriteEnable1, inAddress1, inData1,
               inWriteEnable2, inAddress2, inData2,
        input  inReady, writeEnable, writeAddress, writeData, retireCount
    );

    modport slave (
        input  inValid, inWriteEnable1, inAddress1, inData1,
               inWriteEnable2, inAddress2, inData2,
        output inReady, writeEnable, writeAddress, writeData, retireCount
    );
endinterface

// File: rtl/write_back_unit.sv
// Write-back stage: drives the single register-file write port, serialising
// dual-destination instructions over two cycles, and counts retired instructions.
module write_back_unit #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic                clk,
    input  logic                rst,
    write_back_unit_if.slave    bus
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_SECOND = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [ADDR_W-1:0] r_hold_addr;
    logic [DATA_W-1:0] r_hold_data;
    logic [CNT_W-1:0]  r_count;

    assign bus.inReady      = (r_state == S_IDLE);
    assign bus.writeEnable  = r_wr_en;
    assign bus.writeAddress = r_wr_addr;
    assign bus.writeData    = r_wr_data;
    assign bus.retireCount  = r_count;

    // Accept/drain FSM with registered write port, slot-2 holding register and retire counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= {ADDR_W{1'b0}};
            r_wr_data   <= {DATA_W{1'b0}};
            r_hold_addr <= {ADDR_W{1'b0}};
            r_hold_data <= {DATA_W{1'b0}};
            r_count     <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.inValid) begin
                        r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
                        case ({bus.inWriteEnable1, bus.inWriteEnable2})
                            2'b10: begin
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= bus.inAddress1;
                                r_wr_data <= bus.inData1;
                            end
                            2'b01: begin
                                r_wr_en   <= 1'b1;
                                r_wr_addr <= bus.inAddress2;
                                r_wr_data <= bus.inData2;
                            end
                            2'b11: begin
                                // slot 1 goes out now, slot 2 is parked for the drain cycle
                                r_wr_en     <= 1'b1;
                                r_wr_addr   <= bus.inAddress1;
                                r_wr_data   <= bus.inData1;
                                r_hold_addr <= bus.inAddress2;
                                r_hold_data <= bus.inData2;
                                r_state     <= S_SECOND;
                            end
                            default: begin
                                r_wr_en <= 1'b0;
                            end
                        endcase
                    end else begin
                        r_wr_en <= 1'b0;
                    end
                end
                S_SECOND: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_hold_addr;
                    r_wr_data <= r_hold_data;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_wr_en <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_write_back_unit.sv
// Scoreboard bench for write_back_unit: the driver predicts register-file writes
// and retire counts from each accepted instruction, a monitor checks every cycle.
module tb_write_back_unit;
    localparam int DW = 16;
    localparam int AW = 3;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    write_back_unit_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();
    write_back_unit_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(4))  bus4 ();

    write_back_unit #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Narrow-counter copy fed the same stimulus, used to observe counter wrap
    write_back_unit #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    assign bus4.inValid        = bus.inValid;
    assign bus4.inWriteEnable1 = bus.inWriteEnable1;
    assign bus4.inAddress1     = bus.inAddress1;
    assign bus4.inData1        = bus.inData1;
    assign bus4.inWriteEnable2 = bus.inWriteEnable2;
    assign bus4.inAddress2     = bus.inAddress2;
    assign bus4.inData2        = bus.inData2;

    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            due;
    } wr_t;

    wr_t           exp_q[$];
    int            checks     = 0;
    int            failures   = 0;
    int            cyc        = 0;
    int            second_cyc = -1;
    logic [CW-1:0] model_cnt  = '0;
    logic [AW-1:0] last_a     = '0;
    logic [DW-1:0] last_d     = '0;
    logic          exp_we;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input int due);
        wr_t w;
        w.a = a; w.d = d; w.due = due;
        exp_q.push_back(w);
    endtask

    // Present one instruction; hold it while the unit is stalled, then record predictions
    task automatic issue(input logic v, input logic we1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                         input logic we2, input logic [AW-1:0] a2, input logic [DW-1:0] d2);
        int   tries = 0;
        logic acc   = 1'b0;
        do begin
            @(negedge clk);
            bus.inValid = v;
            bus.inWriteEnable1 = we1; bus.inAddress1 = a1; bus.inData1 = d1;
            bus.inWriteEnable2 = we2; bus.inAddress2 = a2; bus.inData2 = d2;
            acc = v && bus.inReady;
            tries++;
        end while (v && !acc && tries < 4);
        if (v) check("accept_within_bound", {31'd0, acc}, 32'd1);
        if (acc) begin
            model_cnt = model_cnt + 1'b1;
            if (we1) push(a1, d1, cyc + 1);
            if (we2) push(a2, d2, we1 ? cyc + 2 : cyc + 1);
            if (we1 && we2) second_cyc = cyc + 1;
        end
    endtask

    task automatic rand_inputs();
        bus.inValid = 1'($urandom);
        bus.inWriteEnable1 = 1'($urandom); bus.inAddress1 = AW'($urandom); bus.inData1 = DW'($urandom);
        bus.inWriteEnable2 = 1'($urandom); bus.inAddress2 = AW'($urandom); bus.inData2 = DW'($urandom);
    endtask

    // Assert reset at a falling edge for n cycles with random inputs; everything pending is lost
    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        model_cnt  = '0;
        second_cyc = -1;
        rand_inputs();
        repeat (n) begin
            @(negedge clk);
            rand_inputs();
        end
        bus.inValid = 1'b0;
        rst = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) issue(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000);
    endtask

    // Monitor: one step after each rising edge, compare both DUTs to the predictions
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                last_a = '0;
                last_d = '0;
                check("rst_we",    {31'd0, bus.writeEnable}, 32'd0);
                check("rst_addr",  {29'd0, bus.writeAddress}, 32'd0);
                check("rst_data",  {16'd0, bus.writeData}, 32'd0);
                check("rst_ready", {31'd0, bus.inReady}, 32'd1);
                check("rst_count", {16'd0, bus.retireCount}, 32'd0);
                check("rst_count4", {28'd0, bus4.retireCount}, 32'd0);
            end else begin
                exp_we = 1'b0;
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    exp_we = 1'b1;
                    last_a = exp_q[0].a;
                    last_d = exp_q[0].d;
                    void'(exp_q.pop_front());
                end
                check("we",     {31'd0, bus.writeEnable}, {31'd0, exp_we});
                check("addr",   {29'd0, bus.writeAddress}, {29'd0, last_a});
                check("data",   {16'd0, bus.writeData}, {16'd0, last_d});
                check("ready",  {31'd0, bus.inReady}, (cyc == second_cyc) ? 32'd0 : 32'd1);
                check("count",  {16'd0, bus.retireCount}, {16'd0, model_cnt});
                check("we4",    {31'd0, bus4.writeEnable}, {31'd0, exp_we});
                check("count4", {28'd0, bus4.retireCount}, {28'd0, model_cnt[3:0]});
            end
        end
    end

    initial begin
        rand_inputs();
        repeat (3) @(negedge clk);
        rand_inputs();
        bus.inValid = 1'b0;
        rst = 1'b1;
        idle(3);

        // single write, SWAP with a queued follower, slot-2 only, no-write, same address
        issue(1'b1, 1'b1, 3'b101, 16'h5555, 1'b0, 3'd0, 16'h0000);
        idle(2);
        issue(1'b1, 1'b1, 3'b001, 16'hAAAA, 1'b1, 3'b010, 16'h1234);
        issue(1'b1, 1'b1, 3'b011, 16'h0BEE, 1'b0, 3'd0, 16'h0000);
        idle(2);
        issue(1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'b111, 16'hFFFF);
        issue(1'b1, 1'b0, 3'b110, 16'h1111, 1'b0, 3'b001, 16'h2222);
        idle(1);
        issue(1'b1, 1'b1, 3'b100, 16'h0001, 1'b1, 3'b100, 16'h0002);
        idle(3);

        // reset while the slot-2 write is pending
        issue(1'b1, 1'b1, 3'b010, 16'hCAFE, 1'b1, 3'b011, 16'hBEEF);
        do_reset(2);
        idle(3);

        // 17 accepts: narrow counter wraps to 1
        for (int i = 0; i < 17; i++)
            issue(1'b1, 1'b1, AW'(i), DW'(i * 3), 1'b0, 3'd0, 16'h0000);
        idle(2);

        for (int i = 0; i < 300; i++)
            issue($urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom), DW'($urandom),
                  1'($urandom), AW'($urandom), DW'($urandom));
        idle(4);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/write_back_unit.md
# write_back_unit

Write-back stage of the pipeline processor: takes the retiring instruction from the memory/write-back buffer and drives the single register-file write port of the Decode stage (writeAddress / writeEnable / writeData). Instructions with two destinations (SWAP, 32-bit MUL result high/low) are serialized over two consecutive cycles. During the second cycle the unit stalls the upstream buffer through a ready handshake. It also keeps a retired-instruction counter for debug.

## Interface
- DATA_W, 16, register data width
- ADDR_W, 3, register address width (8 registers)
- CNT_W, 16, width of retired-instruction counter
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- inValid  in  1  write-back buffer presents a retiring instruction
- inReady  out  1  unit accepts this cycle; transfer when inValid && inReady at rising clk
- inWriteEnable1  in  1  slot-1 destination valid
- inAddress1  in  ADDR_W  slot-1 destination register
- inData1  in  DATA_W  slot-1 data
- inWriteEnable2  in  1  slot-2 destination valid
- inAddress2  in  ADDR_W  slot-2 destination register
- inData2  in  DATA_W  slot-2 data
- writeEnable  out  1  register-file write strobe (registered)
- writeAddress  out  ADDR_W  register-file write address (registered)
- writeData  out  DATA_W  register-file write data (registered)
- retireCount  out  CNT_W  number of accepted instructions, wraps

## Operation
- FSM with two states: IDLE and SECOND. inReady = (state == IDLE), combinational from state only.
- Accept in IDLE (inValid=1). Next-cycle port value depends on the enables:
  - we1=1, we2=0: port loads slot 1; stay IDLE.
  - we1=0, we2=1: port loads slot 2 directly; stay IDLE. No extra cycle.
  - we1=1, we2=1: port loads slot 1; slot-2 address and data captured into a holding register; go to SECOND.
  - we1=0, we2=0: writeEnable=0, and writeAddress/writeData hold their previous values. The instruction still retires.
- SECOND: on the next edge the port loads the holding register (writeEnable=1), then the FSM returns to IDLE. inValid is ignored in SECOND; upstream must hold its data.
- Any edge without an accept or a SECOND drain loads writeEnable=0. writeEnable is therefore a one-cycle pulse per write.
- Same address in both slots: both writes are issued in order, slot 1 then slot 2, so slot 2's value is final.
- retireCount increments by 1 on every accept, including the no-write case. It never increments on the SECOND drain cycle. It wraps from 2^CNT_W-1 to 0.

## Timing
- Reset (rst=0, asynchronous) drives: state=IDLE, inReady=1, writeEnable=0, writeAddress=0, writeData=0, retireCount=0, holding register=0.
- Reset asserted in SECOND: the pending slot-2 write is discarded and no write is issued after reset release.
- Latency: 1 cycle from the accept edge to writeEnable=1 with slot-1 data.
- Dual-write instruction: writes appear on two consecutive cycles (accept+1, accept+2). inReady is low for exactly one cycle.
- Throughput: one single-write instruction per cycle; a dual-write instruction occupies 2 cycles.
- Outputs are registered: no combinational path from any in* port to writeEnable/writeAddress/writeData.
- The register file samples the port on its clock edge; values stay stable for the full cycle.

## Test plan
- Reset: hold rst=0 with random inputs -> all outputs 0, inReady=1; release rst -> outputs stay 0 until the first accept.
- Single write: accept we1=1, addr1=3'b101, data1=16'h5555 -> next cycle writeEnable=1, writeAddress=5, writeData=16'h5555; the cycle after, writeEnable=0; retireCount=1.
- Dual write (SWAP): accept we1=we2=1, (3'b001, 16'hAAAA), (3'b010, 16'h1234) with a second instruction queued behind it -> cycle+1 writes R1=AAAA with inReady=0; cycle+2 writes R2=1234 with inReady=1; the queued instruction is accepted at cycle+2 and written at cycle+3; retireCount=2.
- Slot-2 only and no-write cases:
  - we1=0, we2=1 on (3'b111, 16'hFFFF) -> single write R7 at cycle+1, no stall.
  - we1=we2=0 -> writeEnable stays 0, retireCount still +1.
- Same-address dual write to R4 with data 16'h0001 then 16'h0002 -> two pulses, last one writes 0002.
- Reset during SECOND: assert rst between the two writes -> no second write appears; after release, inReady=1 and retireCount=0. Counter wrap: with CNT_W=4, 17 accepts -> retireCount=1.
